// File: rtl/irq_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// irq_arbiter_pkg
// Shared definitions for the interrupt arbiter:
//   - register word offsets selected by Addr[3:2]
//   - FSM state encoding
//   - helper that assembles the CUR register read word
// Related configuration macro: IRQ_ARBITER_EDGE_EN (see irq_arbiter.sv).
// -----------------------------------------------------------------------------
package irq_arbiter_pkg;

  // Register offsets (word index within the block)
  localparam logic [1:0] REG_MASK = 2'd0;
  localparam logic [1:0] REG_PEND = 2'd1;
  localparam logic [1:0] REG_CUR  = 2'd2;
  localparam logic [1:0] REG_EOI  = 2'd3;

  // Largest source count the 3-bit id can address
  localparam int unsigned MAX_SRC = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_PRES = 2'd1,
    ST_SERV = 2'd2
  } state_e;

  // CUR read word: active flag in bit 31, source id in bits [2:0]
  function automatic logic [31:0] cur_word(input logic active, input logic [2:0] id);
    return {active, 28'h000_0000, id};
  endfunction

endpackage

// File: rtl/irq_prio_enc.sv
// -----------------------------------------------------------------------------
// irq_prio_enc
// Lowest-index-wins priority encoder.
// Ports:
//   i_req   [N_SRC-1:0]  request vector
//   o_valid              at least one request bit set
//   o_idx   [2:0]        index of the lowest set request bit (0 when none)
// -----------------------------------------------------------------------------
module irq_prio_enc #(
  parameter int N_SRC = 6
) (
  input  logic [N_SRC-1:0] i_req,
  output logic             o_valid,
  output logic [2:0]       o_idx
);

  // Scan from the top down so the lowest set bit is the last one written
  always_comb begin
    logic       found;
    logic [2:0] idx;
    found = 1'b0;
    idx   = 3'd0;
    for (int i = N_SRC - 1; i >= 0; i--) begin
      if (i_req[i]) begin
        found = 1'b1;
        idx   = 3'(i);
      end else begin
        found = found;
        idx   = idx;
      end
    end
    o_valid = found;
    o_idx   = idx;
  end

endmodule

// File: rtl/irq_arbiter.sv
// -----------------------------------------------------------------------------
// irq_arbiter
// Memory-mapped interrupt arbiter. Sources set sticky PEND bits; the lowest
// pending and unmasked source is presented to the CPU until acknowledged,
// then held in service until software writes EOI.
//
// Configuration macro:
//   IRQ_ARBITER_EDGE_EN  defined   -> sources latch on a 0->1 edge of irq_in
//                        undefined -> sources latch while irq_in is high
//
// Ports:
//   clk      clock, rising edge
//   reset    asynchronous active-high reset
//   Addr     [31:2] word address, Addr[3:2] selects MASK/PEND/CUR/EOI
//   WE       register write enable
//   Din      [31:0] write data
//   Dout     [31:0] combinational read data
//   irq_in   [N_SRC-1:0] device interrupt lines
//   IntAck   CPU acknowledge pulse (honoured only while presenting)
//   IRQ      interrupt request to the CPU
//   IntCode  [2:0] id of the presented source
// -----------------------------------------------------------------------------
module irq_arbiter
  import irq_arbiter_pkg::*;
#(
  parameter int N_SRC = 6
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [31:2]      Addr,
  input  logic             WE,
  input  logic [31:0]      Din,
  output logic [31:0]      Dout,
  input  logic [N_SRC-1:0] irq_in,
  input  logic             IntAck,
  output logic             IRQ,
  output logic [2:0]       IntCode
);

  state_e           r_state;
  logic [N_SRC-1:0] r_mask;
  logic [N_SRC-1:0] r_pend;
  logic [2:0]       r_win_id;
  logic             r_cur_active;
  logic [2:0]       r_cur_id;
  logic             r_irq;
  logic [2:0]       r_intcode;

  logic             w_wr_mask;
  logic             w_wr_pend;
  logic             w_wr_eoi;
  logic [N_SRC-1:0] w_set;
  logic [N_SRC-1:0] w_w1c;
  logic [N_SRC-1:0] w_ack_clr;
  logic [N_SRC-1:0] w_pend_nxt;
  logic [N_SRC-1:0] w_mask_nxt;
  logic             w_win_live;
  logic             w_ack;
  logic             w_enc_valid;
  logic [2:0]       w_enc_idx;
  logic             w_unused;

  assign w_wr_mask = WE && (Addr[3:2] == REG_MASK);
  assign w_wr_pend = WE && (Addr[3:2] == REG_PEND);
  assign w_wr_eoi  = WE && (Addr[3:2] == REG_EOI);

  // Upper address bits and unimplemented data bits are intentionally ignored
  assign w_unused = ^{Addr[31:4], Din[31:N_SRC]};

`ifdef IRQ_ARBITER_EDGE_EN
  logic [N_SRC-1:0] r_irq_q;

  // One-cycle history of irq_in for rising-edge detection
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_irq_q <= {N_SRC{1'b0}};
    end else begin
      r_irq_q <= irq_in;
    end
  end

  assign w_set = irq_in & ~r_irq_q;
`else
  assign w_set = irq_in;
`endif

  // The presented source is only still valid while it stays pending and unmasked
  assign w_win_live = r_mask[r_win_id] && r_pend[r_win_id];
  assign w_ack      = (r_state == ST_PRES) && IntAck && w_win_live;
  assign w_w1c      = w_wr_pend ? Din[N_SRC-1:0] : {N_SRC{1'b0}};
  assign w_mask_nxt = w_wr_mask ? Din[N_SRC-1:0] : r_mask;

  // One-hot clear of the acknowledged source
  always_comb begin
    w_ack_clr = {N_SRC{1'b0}};
    for (int i = 0; i < N_SRC; i++) begin
      if (w_ack && (r_win_id == 3'(i))) begin
        w_ack_clr[i] = 1'b1;
      end else begin
        w_ack_clr[i] = 1'b0;
      end
    end
  end

  // New sets win over any clear landing in the same cycle
  assign w_pend_nxt = (r_pend & ~(w_w1c | w_ack_clr)) | w_set;

  irq_prio_enc #(
    .N_SRC (N_SRC)
  ) u_prio_enc (
    .i_req   (r_pend & r_mask),
    .o_valid (w_enc_valid),
    .o_idx   (w_enc_idx)
  );

  // MASK and PEND register storage
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_mask <= {N_SRC{1'b0}};
      r_pend <= {N_SRC{1'b0}};
    end else begin
      r_mask <= w_mask_nxt;
      r_pend <= w_pend_nxt;
    end
  end

  // Arbitration FSM; transitions look at pre-write register values, while IRQ
  // is computed from post-write values so a software mask/clear drops it at once
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state      <= ST_IDLE;
      r_win_id     <= 3'd0;
      r_cur_active <= 1'b0;
      r_cur_id     <= 3'd0;
      r_irq        <= 1'b0;
      r_intcode    <= 3'd0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_enc_valid) begin
            r_win_id  <= w_enc_idx;
            r_state   <= ST_PRES;
            r_irq     <= w_pend_nxt[w_enc_idx] && w_mask_nxt[w_enc_idx];
            r_intcode <= w_enc_idx;
          end else begin
            r_irq     <= 1'b0;
            r_intcode <= 3'd0;
          end
        end
        ST_PRES: begin
          if (!w_win_live) begin
            r_state   <= ST_IDLE;
            r_irq     <= 1'b0;
            r_intcode <= 3'd0;
          end else if (IntAck) begin
            r_cur_active <= 1'b1;
            r_cur_id     <= r_win_id;
            r_state      <= ST_SERV;
            r_irq        <= 1'b0;
            r_intcode    <= 3'd0;
          end else begin
            r_irq     <= w_pend_nxt[r_win_id] && w_mask_nxt[r_win_id];
            r_intcode <= r_win_id;
          end
        end
        ST_SERV: begin
          if (w_wr_eoi) begin
            r_cur_active <= 1'b0;
            r_state      <= ST_IDLE;
          end else begin
            r_state <= ST_SERV;
          end
          r_irq     <= 1'b0;
          r_intcode <= 3'd0;
        end
        default: begin
          r_state   <= ST_IDLE;
          r_irq     <= 1'b0;
          r_intcode <= 3'd0;
        end
      endcase
    end
  end

  assign IRQ     = r_irq;
  assign IntCode = r_intcode;

  // Combinational register read mux
  always_comb begin
    case (Addr[3:2])
      REG_MASK: Dout = {{(32 - N_SRC){1'b0}}, r_mask};
      REG_PEND: Dout = {{(32 - N_SRC){1'b0}}, r_pend};
      REG_CUR:  Dout = cur_word(r_cur_active, r_cur_id);
      REG_EOI:  Dout = 32'h0000_0000;
      default:  Dout = 32'h0000_0000;
    endcase
  end

endmodule

// File: tb/tb_irq_arbiter.sv
// -----------------------------------------------------------------------------
// tb_irq_arbiter
// Directed self-checking bench for irq_arbiter (N_SRC = 6). Expected values
// are queued when stimulus is driven and popped when the DUT output is sampled.
// Build with or without IRQ_ARBITER_EDGE_EN; the held-line check adapts.
// -----------------------------------------------------------------------------
module tb_irq_arbiter;

  localparam logic [1:0] A_MASK = 2'd0;
  localparam logic [1:0] A_PEND = 2'd1;
  localparam logic [1:0] A_CUR  = 2'd2;
  localparam logic [1:0] A_EOI  = 2'd3;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:2] Addr;
  logic        WE;
  logic [31:0] Din;
  logic [31:0] Dout;
  logic [5:0]  irq_in;
  logic        IntAck;
  logic        IRQ;
  logic [2:0]  IntCode;

  string       tag_q[$];
  logic [31:0] exp_q[$];
  int          n_cmp = 0;
  int          n_err = 0;

  irq_arbiter #(.N_SRC(6)) dut (
    .clk     (clk),
    .reset   (reset),
    .Addr    (Addr),
    .WE      (WE),
    .Din     (Din),
    .Dout    (Dout),
    .irq_in  (irq_in),
    .IntAck  (IntAck),
    .IRQ     (IRQ),
    .IntCode (IntCode)
  );

  always #50 clk = ~clk;

  task automatic expect_val(input string tag, input logic [31:0] v);
    tag_q.push_back(tag);
    exp_q.push_back(v);
  endtask

  task automatic check(input logic [31:0] obs);
    string       t;
    logic [31:0] e;
    n_cmp++;
    if (exp_q.size() == 0) begin
      n_err++;
      $error("FAIL scoreboard_empty: observed %h required nothing", obs);
    end else begin
      t = tag_q.pop_front();
      e = exp_q.pop_front();
      assert (obs === e) else begin
        n_err++;
        $error("FAIL %s: observed %h expected %h", t, obs, e);
      end
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    Addr = 30'(a);
    Din  = d;
    WE   = 1'b1;
    tick(1);
    WE   = 1'b0;
    Din  = 32'h0000_0000;
  endtask

  task automatic rd_chk(input logic [1:0] a, input string tag, input logic [31:0] v);
    expect_val(tag, v);
    Addr = 30'(a);
    #1;
    check(Dout);
  endtask

  // IntCode is only defined while IRQ is up, so it is compared only then
  task automatic irq_chk(input string tag, input logic irq, input logic [2:0] code);
    expect_val({tag, "_irq"}, {31'h0, irq});
    check({31'h0, IRQ});
    if (irq) begin
      expect_val({tag, "_code"}, {29'h0, code});
      check({29'h0, IntCode});
    end
  endtask

  task automatic ack();
    IntAck = 1'b1;
    tick(1);
    IntAck = 1'b0;
  endtask

  initial begin
    reset  = 1'b0;
    Addr   = 30'h0;
    WE     = 1'b0;
    Din    = 32'h0000_0000;
    irq_in = 6'h00;
    IntAck = 1'b0;

    // Reset asserted before any clock edge
    #1 reset = 1'b1;
    #1;
    irq_chk("rst", 1'b0, 3'd0);
    rd_chk(A_CUR,  "rst_cur",  32'h0000_0000);
    rd_chk(A_MASK, "rst_mask", 32'h0000_0000);
    rd_chk(A_PEND, "rst_pend", 32'h0000_0000);
    tick(2);
    reset = 1'b0;
    tick(1);

    // Single pulse on source 2, two-edge latency, acknowledge
    wr(A_MASK, 32'hFFFF_FFFF);
    rd_chk(A_MASK, "s31_mask_unused", 32'h0000_003F);
    irq_in = 6'b000100;
    tick(1);
    irq_in = 6'h00;
    rd_chk(A_PEND, "s31_pend", 32'h0000_0004);
    irq_chk("s31_edge1", 1'b0, 3'd0);
    tick(1);
    irq_chk("s31_edge2", 1'b1, 3'd2);
    ack();
    rd_chk(A_CUR,  "s31_cur",  32'h8000_0002);
    rd_chk(A_PEND, "s31_pend_clr", 32'h0000_0000);
    irq_chk("s31_serv", 1'b0, 3'd0);
    rd_chk(A_EOI, "s31_eoi_rd", 32'h0000_0000);
    wr(A_EOI, 32'hDEAD_BEEF);
    rd_chk(A_CUR, "s31_cur_eoi", 32'h0000_0002);

    // Sources 4 and 1 together: lowest index first
    irq_in = 6'b010010;
    tick(1);
    irq_in = 6'h00;
    tick(1);
    irq_chk("s32_first", 1'b1, 3'd1);
    ack();
    rd_chk(A_PEND, "s32_pend", 32'h0000_0010);
    rd_chk(A_CUR,  "s32_cur1", 32'h8000_0001);
    wr(A_EOI, 32'h0000_0000);
    tick(1);
    irq_chk("s32_second", 1'b1, 3'd4);
    ack();
    wr(A_EOI, 32'h0000_0000);
    rd_chk(A_PEND, "s32_pend_end", 32'h0000_0000);
    rd_chk(A_CUR,  "s32_cur_end",  32'h0000_0004);

    // Masked source stays pending; unmasking presents it; W1C withdraws it
    wr(A_MASK, 32'h0000_0000);
    irq_in = 6'b001000;
    tick(1);
    irq_in = 6'h00;
    tick(2);
    rd_chk(A_PEND, "s33_pend", 32'h0000_0008);
    irq_chk("s33_masked", 1'b0, 3'd0);
    wr(A_MASK, 32'h0000_0008);
    irq_chk("s33_unmask_wr", 1'b0, 3'd0);
    tick(1);
    irq_chk("s33_pres", 1'b1, 3'd3);
    wr(A_PEND, 32'h0000_0008);
    irq_chk("s33_w1c_drop", 1'b0, 3'd0);
    tick(1);
    rd_chk(A_PEND, "s33_pend_clr", 32'h0000_0000);
    irq_chk("s33_idle", 1'b0, 3'd0);

    // Present id 5, winner frozen, masking withdraws, late IntAck ignored
    wr(A_MASK, 32'h0000_003F);
    irq_in = 6'b100000;
    tick(1);
    irq_in = 6'h00;
    tick(1);
    irq_chk("s34_pres", 1'b1, 3'd5);
    irq_in = 6'b000001;
    tick(1);
    irq_in = 6'h00;
    irq_chk("s34_frozen", 1'b1, 3'd5);
    rd_chk(A_PEND, "s34_pend", 32'h0000_0021);
    wr(A_MASK, 32'h0000_0000);
    irq_chk("s34_mask_drop", 1'b0, 3'd0);
    IntAck = 1'b1;
    tick(2);
    IntAck = 1'b0;
    irq_chk("s34_late_ack", 1'b0, 3'd0);
    rd_chk(A_CUR,  "s34_cur",  32'h0000_0004);
    rd_chk(A_PEND, "s34_pend_kept", 32'h0000_0021);
    wr(A_PEND, 32'hFFFF_FFFF);
    rd_chk(A_PEND, "s34_pend_w1c", 32'h0000_0000);

    // Pendings accumulate during service; EOI releases the next one
    wr(A_MASK, 32'h0000_003F);
    irq_in = 6'b001000;
    tick(1);
    irq_in = 6'h00;
    tick(1);
    irq_chk("s35_pres3", 1'b1, 3'd3);
    ack();
    rd_chk(A_CUR, "s35_cur3", 32'h8000_0003);
    irq_in = 6'b000001;
    tick(1);
    irq_in = 6'h00;
    tick(2);
    irq_chk("s35_serv_hold", 1'b0, 3'd0);
    rd_chk(A_PEND, "s35_pend", 32'h0000_0001);
    ack();
    rd_chk(A_CUR,  "s35_ack_serv_cur",  32'h8000_0003);
    rd_chk(A_PEND, "s35_ack_serv_pend", 32'h0000_0001);
    wr(A_EOI, 32'h1234_5678);
    irq_chk("s35_eoi_edge", 1'b0, 3'd0);
    tick(1);
    irq_chk("s35_pres0", 1'b1, 3'd0);
    wr(A_EOI, 32'h0000_0000);
    irq_chk("s35_eoi_in_pres", 1'b1, 3'd0);
    rd_chk(A_CUR, "s35_cur_idle", 32'h0000_0003);
    ack();
    rd_chk(A_CUR,  "s35_cur0",  32'h8000_0000);
    rd_chk(A_PEND, "s35_pend0", 32'h0000_0000);

    // Reset mid-cycle while in service
    irq_in = 6'b000100;
    tick(1);
    irq_in = 6'h00;
    rd_chk(A_PEND, "s36_pend_pre", 32'h0000_0004);
    #10 reset = 1'b1;
    #1;
    irq_chk("s36_rst", 1'b0, 3'd0);
    rd_chk(A_CUR,  "s36_cur",  32'h0000_0000);
    rd_chk(A_PEND, "s36_pend", 32'h0000_0000);
    rd_chk(A_MASK, "s36_mask", 32'h0000_0000);
    tick(1);
    reset = 1'b0;
    tick(1);
    irq_chk("s36_after", 1'b0, 3'd0);

    // Held line: edge mode latches once, level mode keeps re-setting
    irq_in = 6'b000001;
    tick(3);
    rd_chk(A_PEND, "s36_held", 32'h0000_0001);
    wr(A_PEND, 32'h0000_0001);
    tick(2);
`ifdef IRQ_ARBITER_EDGE_EN
    rd_chk(A_PEND, "s36_held_w1c", 32'h0000_0000);
`else
    rd_chk(A_PEND, "s36_held_w1c", 32'h0000_0001);
`endif
    irq_chk("s36_masked", 1'b0, 3'd0);
    irq_in = 6'h00;
    tick(1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
